// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the program counter and drives a req/ack instruction-memory port.
// Returned words are buffered in a 2-entry queue, and one instruction per
// cycle is presented to IF/ID. An all-zero instruction_out is the bubble.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   imem_req/imem_addr      fetch request and address (address held until ack)
//   imem_ack/imem_data      ack and returned word (ack may come same cycle)
//   stall                   downstream hold, freezes the output register
//   branch_taken/target     one-cycle redirect pulse and new PC
//   instruction_out/pc_out  registered instruction and its PC
//   fetch_valid             instruction_out carries a real instruction
//
// state | meaning
// FETCH | issue a request at pc whenever the queue has room
// WAIT  | request outstanding, address held until ack
// FLUSH | redirect pending, old request drained and its data dropped
module instr_fetch #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int                 PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [31:0]       instruction_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              fetch_valid
);

   typedef enum logic [1:0] {FETCH, WAIT, FLUSH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] target_saved;
   logic [31:0]       q_word [2];
   logic [ADDR_W-1:0] q_pc   [2];
   logic [1:0]        count;
   logic              acked;
   logic              push;
   logic              pop;
   logic              wr_sel;

   // Request depends only on state, queue occupancy and reset, never on
   // stall; reset gating keeps the port quiet during the reset cycle.
   assign imem_req  = !reset && ((state != FETCH) || (count < 2'd2));
   assign imem_addr = pc;
   assign pc_next   = pc + ADDR_W'(PC_STEP);

   assign acked = imem_req && imem_ack;
   assign push  = acked && (state != FLUSH) && !branch_taken;
   assign pop   = !branch_taken && !stall && (count != 2'd0);
   // Slot written by a push, accounting for a simultaneous shift-down.
   assign wr_sel = pop ? (count == 2'd2) : (count == 2'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= FETCH;
         pc              <= RESET_PC;
         target_saved    <= RESET_PC;
         count           <= 2'd0;
         instruction_out <= '0;
         pc_out          <= '0;
         fetch_valid     <= 1'b0;
      end else begin
         if (branch_taken) begin
            if (imem_req && !imem_ack) begin
               state        <= FLUSH;
               target_saved <= branch_target;
            end else begin
               state <= FETCH;
               pc    <= branch_target;
            end
         end else begin
            case (state)
               FETCH: begin
                  if (imem_req) begin
                     if (imem_ack) pc <= pc_next;
                     else          state <= WAIT;
                  end
               end
               WAIT: begin
                  if (imem_ack) begin
                     pc    <= pc_next;
                     state <= FETCH;
                  end
               end
               FLUSH: begin
                  if (imem_ack) begin
                     pc    <= target_saved;
                     state <= FETCH;
                  end
               end
               default: state <= FETCH;
            endcase
         end

         if (branch_taken) begin
            count <= 2'd0;
         end else begin
            if (pop) begin
               q_word[0] <= q_word[1];
               q_pc[0]   <= q_pc[1];
            end
            if (push) begin
               q_word[wr_sel] <= imem_data;
               q_pc[wr_sel]   <= pc;
            end
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
         end

         if (branch_taken) begin
            instruction_out <= '0;
            fetch_valid     <= 1'b0;
         end else if (!stall) begin
            if (count != 2'd0) begin
               instruction_out <= q_word[0];
               pc_out          <= q_pc[0];
               fetch_valid     <= 1'b1;
            end else begin
               instruction_out <= '0;
               fetch_valid     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: bench for instr_fetch. A cycle table covers reset, zero-wait
// streaming and a 5-cycle stall; a scoreboard fed by memory acks checks every
// delivered instruction; hand sequences cover wait states, redirects and reset.
// A second instance starts at 0xFFFFFFFC to exercise address wrap.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset, stall, branch_taken;
   logic [31:0] branch_target;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_data, instruction_out, pc_out;
   logic        fetch_valid;

   logic        w_req, w_ack, w_valid;
   logic [31:0] w_addr, w_data, w_instr, w_pc;

   int total = 0;
   int bad   = 0;
   int ws    = 0;
   int wcnt  = 0;
   int delivered = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   always_comb begin
      imem_ack  = imem_req && (wcnt >= ws);
      imem_data = mem_word(imem_addr);
      w_ack     = w_req;
      w_data    = mem_word(w_addr);
   end

   always @(posedge clk) wcnt <= (reset || !imem_req || imem_ack) ? 0 : wcnt + 1;

   instr_fetch dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .instruction_out(instruction_out), .pc_out(pc_out), .fetch_valid(fetch_valid)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_data(w_data), .stall(1'b0),
      .branch_taken(1'b0), .branch_target(32'h0),
      .instruction_out(w_instr), .pc_out(w_pc), .fetch_valid(w_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted, non-discarded acks push the expected word in
   // program order; each output edge pops per the output-register rules.
   typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;
   ent_t        sb [$];
   ent_t        ent;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] m_instr = 32'h0, m_pc = 32'h0;
   logic        m_valid = 1'b0, flushing = 1'b0;
   logic        s_rst, s_req, s_ack, s_stall, s_br;
   logic [31:0] s_addr, s_tgt;

   always begin
      @(negedge clk);
      #2;
      s_rst = reset; s_req = imem_req; s_ack = imem_ack; s_addr = imem_addr;
      s_stall = stall; s_br = branch_taken; s_tgt = branch_target;
      @(posedge clk);
      #1;
      if (s_rst) begin
         sb.delete();
         exp_pc = 32'h0; flushing = 1'b0;
         m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
      end else if (s_br) begin
         sb.delete();
         flushing = s_req && !s_ack;
         exp_pc   = s_tgt;
         m_instr  = 32'h0; m_valid = 1'b0;
      end else begin
         if (!s_stall) begin
            if (sb.size() != 0) begin
               ent = sb.pop_front();
               m_instr = ent.word; m_pc = ent.pc; m_valid = 1'b1;
               delivered++;
            end else begin
               m_instr = 32'h0; m_valid = 1'b0;
            end
         end
         if (s_req && s_ack) begin
            if (flushing) flushing = 1'b0;
            else begin
               chk("fetch_addr", s_addr, exp_pc);
               sb.push_back('{mem_word(exp_pc), exp_pc});
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
      chk("sb_valid", {31'h0, fetch_valid}, {31'h0, m_valid});
      chk("sb_instr", instruction_out, m_instr);
      chk("sb_pc", pc_out, m_pc);
      if (!s_rst && s_req && !s_ack) begin
         chk("req_held", {31'h0, imem_req}, 32'h1);
         chk("addr_held", imem_addr, s_addr);
      end
   end

   typedef struct {
      logic rst, stl, req; logic [31:0] addr;
      logic valid; logic [31:0] instr, pc;
      logic wchk; logic [31:0] waddr; logic wpchk; logic [31:0] wpc;
   } vec_t;

   function automatic vec_t mkv(input logic rst, input logic stl, input logic req,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.stl = stl; v.req = req; v.addr = addr;
      v.valid = valid; v.pc = pc; v.instr = valid ? mem_word(pc) : 32'h0;
      v.wchk = 1'b0; v.waddr = 32'h0; v.wpchk = 1'b0; v.wpc = 32'h0;
      return v;
   endfunction

   vec_t vt [14];
   int   d0, n;
   logic found;

   initial begin
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      vt[0]  = mkv(1, 0, 0, 0,  0, 0);
      vt[1]  = mkv(0, 0, 1, 0,  0, 0);
      vt[2]  = mkv(0, 0, 1, 4,  0, 0);
      vt[3]  = mkv(0, 0, 1, 8,  1, 0);
      vt[4]  = mkv(0, 0, 1, 12, 1, 4);
      vt[5]  = mkv(0, 1, 1, 16, 1, 8);
      vt[6]  = mkv(0, 1, 0, 0,  1, 8);
      vt[7]  = mkv(0, 1, 0, 0,  1, 8);
      vt[8]  = mkv(0, 1, 0, 0,  1, 8);
      vt[9]  = mkv(0, 1, 0, 0,  1, 8);
      vt[10] = mkv(0, 0, 0, 0,  1, 8);
      vt[11] = mkv(0, 0, 1, 20, 1, 12);
      vt[12] = mkv(0, 0, 1, 24, 1, 16);
      vt[13] = mkv(0, 0, 1, 28, 1, 20);
      vt[1].wchk = 1'b1; vt[1].waddr = 32'hFFFF_FFFC;
      vt[2].wchk = 1'b1; vt[2].waddr = 32'h0000_0000;
      vt[3].wchk = 1'b1; vt[3].waddr = 32'h0000_0004;
      vt[3].wpchk = 1'b1; vt[3].wpc = 32'hFFFF_FFFC;
      vt[4].wpchk = 1'b1; vt[4].wpc = 32'h0000_0000;

      repeat (2) @(posedge clk);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         reset = vt[i].rst; stall = vt[i].stl;
         #1;
         chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].req});
         if (vt[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].addr);
         chk($sformatf("tbl%0d_valid", i), {31'h0, fetch_valid}, {31'h0, vt[i].valid});
         chk($sformatf("tbl%0d_instr", i), instruction_out, vt[i].instr);
         chk($sformatf("tbl%0d_pc", i), pc_out, vt[i].pc);
         if (vt[i].wchk)  chk($sformatf("tbl%0d_wrap_addr", i), w_addr, vt[i].waddr);
         if (vt[i].wpchk) chk($sformatf("tbl%0d_wrap_pc", i), w_pc, vt[i].wpc);
      end

      // Two wait states per ack: every word must still arrive, in order.
      @(negedge clk); reset = 1'b1; stall = 1'b0; ws = 2;
      @(negedge clk); reset = 1'b0;
      d0 = delivered;
      repeat (40) @(negedge clk);
      chk("ws2_delivered_ge10", {31'h0, (delivered - d0) >= 10}, 32'h1);

      // Redirect to 0x100 while the request to 0x20 is outstanding.
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'h20 && wcnt == 0) found = 1'b1;
      end
      chk("find_req_0x20", {31'h0, found}, 32'h1);
      branch_taken = 1'b1; branch_target = 32'h100;
      @(negedge clk); branch_taken = 1'b0;
      #1;
      chk("flush_addr_kept", imem_addr, 32'h20);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (imem_req && imem_addr != 32'h20) found = 1'b1;
      end
      chk("redirect_seen", {31'h0, found}, 32'h1);
      chk("redirect_addr", imem_addr, 32'h100);
      d0 = delivered;
      repeat (20) @(negedge clk);
      chk("redirect_delivered", {31'h0, (delivered - d0) >= 3}, 32'h1);

      // Redirect on the same edge as an ack, with stall also high.
      reset = 1'b1; ws = 0;
      @(negedge clk); reset = 1'b0;
      repeat (6) @(negedge clk);
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
      #1;
      chk("br_ack_same_cycle", {31'h0, imem_ack}, 32'h1);
      @(negedge clk); stall = 1'b0; branch_taken = 1'b0;
      #1;
      chk("br_stall_valid", {31'h0, fetch_valid}, 32'h0);
      chk("br_stall_instr", instruction_out, 32'h0);
      chk("br_next_req", {31'h0, imem_req}, 32'h1);
      chk("br_next_addr", imem_addr, 32'h200);
      repeat (10) @(negedge clk);

      // Reset while a request sits in WAIT.
      ws = 2;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (imem_req && !imem_ack && wcnt == 1) found = 1'b1;
      end
      chk("find_wait", {31'h0, found}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_req_now", {31'h0, imem_req}, 32'h0);
      @(negedge clk);
      #1;
      chk("rst_req_next", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
      chk("rst_instr", instruction_out, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      reset = 1'b0;
      #1;
      chk("restart_req", {31'h0, imem_req}, 32'h1);
      chk("restart_addr", imem_addr, 32'h0);
      n = 0;
      repeat (12) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
